bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial stage that drives the single-bit input of the sequence detector FSMs. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled cycle, with a qualifying valid. A one-word holding register lets the next word queue during shifting, so back-to-back words stream with no idle bit slots.

## Interface
- WIDTH, 8, bits per word; must be ≥ 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is sampled on clk.
- data_in  in  WIDTH  word to serialize.
- load_valid  in  1  data_in is valid this cycle.
- load_ready  out  1  block can accept a word this cycle; equals ~hold_full.
- shift_en  in  1  downstream consumes the current bit this cycle.
- bit_out  out  1  current serial bit; forced to 0 when bit_valid = 0.
- bit_valid  out  1  bit_out is meaningful; high exactly in SHIFT state.
- word_done  out  1  one-cycle pulse, registered; high the cycle after the last bit of a word is consumed.

## Operation
- Internal state: state {IDLE, SHIFT}, shift register sreg[WIDTH], bit counter cnt[$clog2(WIDTH)], hold[WIDTH], hold_full.
- Accept: accept = load_valid && load_ready.
- Consume: consume = bit_valid && shift_en.
- Last: last = consume && (cnt == WIDTH-1).
- bit_out is sreg[WIDTH-1] when MSB_FIRST = 1, sreg[0] otherwise.
- On consume without last: sreg shifts toward the output end, zero fill; cnt increments.
- IDLE:
  - hold_full is always 0.
  - On accept: sreg <= data_in, cnt <= 0, next state SHIFT.
- SHIFT, not last:
  - On accept: hold <= data_in, hold_full <= 1.
  - No consume: sreg and cnt hold; bit_out is stable while shift_en is low.
- SHIFT, last, hold_full = 1:
  - sreg <= hold, cnt <= 0, stay SHIFT.
  - hold_full <= 0. load_ready is 0 this cycle, so no simultaneous accept is possible.
- SHIFT, last, hold_full = 0, accept:
  - Bypass: sreg <= data_in, cnt <= 0, stay SHIFT. hold is not written.
- SHIFT, last, hold_full = 0, no accept: next state IDLE.
- word_done <= last on every edge.
- load_valid while load_ready = 0 is ignored. Upstream holds data until accepted.
- Reset values: state IDLE, sreg 0, cnt 0, hold 0, hold_full 0.
- Output values during reset: bit_out 0, bit_valid 0, word_done 0, load_ready 1.
- Reset mid-word discards the partial word and any held word. Nothing resumes after release.

## Timing
- Accept on edge k (state IDLE):
  - bit_valid = 1 from cycle k+1.
  - First bit on bit_out during cycle k+1.
- With shift_en tied high, a word occupies exactly WIDTH consecutive cycles.
- The cycle after the last bit shows either the next word's first bit (hold or bypass) or bit_valid = 0.
- word_done is high in the cycle after the last-bit consume cycle. In streaming, this coincides with the next word's first bit.
- Sustained throughput: one word per WIDTH enabled cycles.
- load_ready drops the cycle after a word is captured into hold. It rises the cycle after the hold→sreg transfer.

## Test plan
- Single word, MSB first:
  - Stimulus: data_in = 8'hD8 accepted at edge 0; shift_en = 1.
  - Response: bit_out = 1,1,0,1,1,0,0,0 in cycles 1–8; bit_valid high in cycles 1–8, low in cycle 9; word_done high in cycle 9.
  - Feeding a non-overlapping 11011 detector gives exactly one detect pulse.
- Back-to-back streaming:
  - Stimulus: 8'hD8 accepted, then 8'h1B offered with load_valid held.
  - Response: 8'h1B is captured into hold; load_ready is 0 until its transfer; bit_valid is high for 16 contiguous cycles; bit sequence D8 then 1B MSB-first.
- Stall:
  - Stimulus: 8'hA5, shift_en low for 3 cycles after the 2nd bit.
  - Response: bit_out stays 0 (bit 6) for those cycles; the remaining bits 1,0,0,1,0,1 follow with no loss; bit_valid is high for 11 cycles.
- Bypass at last bit:
  - Stimulus: hold empty; accept 8'hFF in the cycle the last bit of 8'h00 is consumed.
  - Response: no gap; 8 zeros, then 8 ones; load_ready stays 1 throughout.
- LSB first:
  - Stimulus: MSB_FIRST = 0, data_in = 8'h0B.
  - Response: bit_out = 1,1,0,1,0,0,0,0.
- Reset mid-word:
  - Stimulus: rst driven low asynchronously after 3 bits of 8'hD8, with a word in hold.
  - Response: bit_valid, bit_out and word_done go 0 immediately, without a clock edge, and load_ready goes 1. After release, no bits are emitted until a new accept.

Source files
------------

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
//   Handshake bundle between a word producer, the bit_serializer and the
//   downstream single-bit consumer.
//
//   data_in    [WIDTH] producer -> serializer : word to serialize
//   load_valid        producer -> serializer : data_in is valid
//   load_ready        serializer -> producer : a word can be accepted
//   shift_en          consumer -> serializer : current bit consumed this cycle
//   bit_out           serializer -> consumer : current serial bit (0 when idle)
//   bit_valid         serializer -> consumer : bit_out is meaningful
//   word_done         serializer -> consumer : pulse after a word's last bit
//
//   master : drives the inputs of the serializer (producer/consumer side)
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             bit_out;
  logic             bit_valid;
  logic             word_done;

  modport master (
    output data_in, load_valid, shift_en,
    input  load_ready, bit_out, bit_valid, word_done
  );

  modport slave (
    input  data_in, load_valid, shift_en,
    output load_ready, bit_out, bit_valid, word_done
  );

endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial stage. Accepts WIDTH-bit words over a valid/ready
//   handshake and emits them one bit per enabled cycle. A one-word holding
//   register lets the next word queue while the current one shifts, so
//   consecutive words stream without idle bit slots.
//
//   Parameters
//     WIDTH      bits per word (>= 2)
//     MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   bit_serializer_if.slave handshake bundle
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_serializer_if.slave       bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_cnt;
  logic             r_hold_full;
  logic             r_word_done;

  logic             w_in_shift;
  logic             w_accept;
  logic             w_consume;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;

  assign w_in_shift = (r_state == SHIFT);
  assign w_accept   = bus.load_valid & ~r_hold_full;
  assign w_consume  = w_in_shift & bus.shift_en;
  assign w_last     = w_consume & (r_cnt == LAST_IDX);

  // Move the next bit into the output position, zero fill from the far end.
  assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_sreg[WIDTH-1:1]};

  assign bus.load_ready = ~r_hold_full;
  assign bus.bit_valid  = w_in_shift;
  assign bus.bit_out    = w_in_shift & (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]);
  assign bus.word_done  = r_word_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every register sees
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = SHIFT;
      SHIFT: if (w_last && !r_hold_full && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg      <= '0;
      r_hold      <= '0;
      r_cnt       <= '0;
      r_hold_full <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= w_last;

      if (!w_in_shift) begin
        if (w_accept) begin
          r_sreg <= bus.data_in;
          r_cnt  <= '0;
        end
      end else if (w_last) begin
        // A queued word has priority; load_ready is low, so no accept races it.
        if (r_hold_full) begin
          r_sreg      <= r_hold;
          r_cnt       <= '0;
          r_hold_full <= 1'b0;
        end else if (w_accept) begin
          // Bypass the empty holding register straight into the shifter.
          r_sreg <= bus.data_in;
          r_cnt  <= '0;
        end
      end else begin
        if (w_consume) begin
          r_sreg <= w_shifted;
          r_cnt  <= r_cnt + CW'(1);
        end
        if (w_accept) begin
          r_hold      <= bus.data_in;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//   Drives an MSB-first and an LSB-first serializer with identical stimulus.
//   The reference model views the block as a queue of at most two pending
//   words plus a bit index into the front word; every falling edge the outputs
//   of both instances are compared with it. Directed scenarios pin both the
//   model and the RTL to hand-computed bit streams.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) if_m ();
  bit_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.data_in    = data_in;
  assign if_m.load_valid = load_valid;
  assign if_m.shift_en   = shift_en;
  assign if_l.data_in    = data_in;
  assign if_l.load_valid = load_valid;
  assign if_l.shift_en   = shift_en;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending words in arrival order, bit index into the front.
  // ---------------------------------------------------------------------------
  logic [W-1:0] wq[$];
  int           bi = 0;
  logic         m_done = 1'b0;
  logic         m_acc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wq.delete();
      bi     = 0;
      m_done = 1'b0;
      m_acc  = 1'b0;
    end else begin
      logic acc, cons, lst;
      acc  = load_valid && (wq.size() < 2);
      cons = (wq.size() > 0) && shift_en;
      lst  = cons && (bi == W - 1);
      m_done = lst;
      if (lst) begin
        void'(wq.pop_front());
        bi = 0;
      end else if (cons) begin
        bi++;
      end
      if (acc) wq.push_back(data_in);
      m_acc = acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Observation state for the directed scenarios
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  logic [31:0] sm_v, sl_v, mm_v;
  int          sm_n, sl_n;
  int          done_cnt, done_cyc, ready_low, v_first, v_last;

  always @(posedge clk) cyc++;

  task automatic clear_obs();
    sm_v = '0; sl_v = '0; mm_v = '0;
    sm_n = 0;  sl_n = 0;
    done_cnt = 0; done_cyc = 0; ready_low = 0;
    v_first = -1; v_last = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] fw;
    logic         mv, eb_m, eb_l;
    mv   = (wq.size() > 0);
    eb_m = 1'b0;
    eb_l = 1'b0;
    if (mv) begin
      fw   = wq[0];
      eb_m = fw[W-1-bi];
      eb_l = fw[bi];
    end
    check("msb_bit_valid",  32'(if_m.bit_valid),  32'(mv));
    check("msb_bit_out",    32'(if_m.bit_out),    32'(eb_m));
    check("msb_load_ready", 32'(if_m.load_ready), 32'(wq.size() < 2));
    check("msb_word_done",  32'(if_m.word_done),  32'(m_done));
    check("lsb_bit_valid",  32'(if_l.bit_valid),  32'(mv));
    check("lsb_bit_out",    32'(if_l.bit_out),    32'(eb_l));
    check("lsb_load_ready", 32'(if_l.load_ready), 32'(wq.size() < 2));
    check("lsb_word_done",  32'(if_l.word_done),  32'(m_done));

    if (if_m.bit_valid) begin
      sm_v = {sm_v[30:0], if_m.bit_out};
      sm_n++;
      if (v_first < 0) v_first = cyc;
      v_last = cyc;
    end
    if (if_l.bit_valid) begin
      sl_v = {sl_v[30:0], if_l.bit_out};
      sl_n++;
    end
    if (mv) mm_v = {mm_v[30:0], eb_m};
    if (if_m.word_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!if_m.load_ready) ready_low++;
  end

  // Apply one set of inputs across the next rising edge.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic se);
    load_valid = lv;
    data_in    = d;
    shift_en   = se;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         lv;
    logic [W-1:0] d;
    logic         se;

    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(if_m.load_ready), 32'd1);
    check("reset_valid", 32'(if_m.bit_valid),  32'd0);
    rst = 1'b1;
    idle(2);

    // Single word, MSB first (LSB instance sees the reversed stream).
    clear_obs();
    step(1'b1, 8'hD8, 1'b1);
    idle(10);
    check("d8_bits_msb",  sm_v, 32'hD8);
    check("d8_len",       32'(sm_n), 32'd8);
    check("d8_bits_lsb",  sl_v, 32'h1B);
    check("d8_model",     mm_v, 32'hD8);
    check("d8_done_cnt",  32'(done_cnt), 32'd1);
    check("d8_done_cyc",  32'(done_cyc - v_first), 32'd8);

    // Back-to-back: second word queues in hold.
    clear_obs();
    step(1'b1, 8'hD8, 1'b1);
    step(1'b1, 8'h1B, 1'b1);
    idle(20);
    check("b2b_bits_msb",  sm_v, 32'hD81B);
    check("b2b_bits_lsb",  sl_v, 32'h1BD8);
    check("b2b_len",       32'(sm_n), 32'd16);
    check("b2b_contig",    32'(v_last - v_first + 1), 32'd16);
    check("b2b_ready_low", 32'(ready_low), 32'd7);
    check("b2b_done_cnt",  32'(done_cnt), 32'd2);

    // Stall on the second bit for three cycles.
    clear_obs();
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    idle(12);
    check("stall_bits_msb", sm_v, 32'h425);
    check("stall_bits_lsb", sl_v, 32'h425);
    check("stall_len",      32'(sm_n), 32'd11);

    // Bypass: next word accepted on the last-bit consume edge, hold empty.
    clear_obs();
    step(1'b1, 8'h00, 1'b1);
    repeat (7) step(1'b0, '0, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    idle(12);
    check("byp_bits_msb",  sm_v, 32'h00FF);
    check("byp_bits_lsb",  sl_v, 32'h00FF);
    check("byp_contig",    32'(v_last - v_first + 1), 32'd16);
    check("byp_ready_low", 32'(ready_low), 32'd0);

    // LSB-first pattern.
    clear_obs();
    step(1'b1, 8'h0B, 1'b1);
    idle(10);
    check("lsbw_bits_lsb", sl_v, 32'hD0);
    check("lsbw_bits_msb", sm_v, 32'h0B);

    // Asynchronous reset mid-word with a word in hold.
    clear_obs();
    step(1'b1, 8'hD8, 1'b1);
    step(1'b1, 8'h1B, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    #2;
    check("rst_pre_valid", 32'(if_m.bit_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_msb_valid", 32'(if_m.bit_valid),  32'd0);
    check("rst_msb_bit",   32'(if_m.bit_out),    32'd0);
    check("rst_msb_done",  32'(if_m.word_done),  32'd0);
    check("rst_msb_ready", 32'(if_m.load_ready), 32'd1);
    check("rst_lsb_valid", 32'(if_l.bit_valid),  32'd0);
    check("rst_lsb_ready", 32'(if_l.load_ready), 32'd1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    rst = 1'b1;
    clear_obs();
    idle(12);
    check("rst_after_bits", 32'(sm_n + sl_n), 32'd0);
    check("rst_after_done", 32'(done_cnt), 32'd0);

    // Randomized traffic; upstream keeps a word stable until it is taken.
    lv = 1'b0;
    d  = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!(lv && !m_acc)) begin
        lv = ($urandom_range(0, 2) != 0);
        d  = W'($urandom);
      end
      se = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        lv  = 1'b0;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        rst = 1'b1;
      end
      step(lv, d, se);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
